// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU and its
// combinational datapath.
package alu_pkg;

   localparam int OP_W = 4;

   localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
   localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
   localparam logic [OP_W-1:0] OP_AND  = 4'd2;
   localparam logic [OP_W-1:0] OP_OR   = 4'd3;
   localparam logic [OP_W-1:0] OP_SRL  = 4'd4;
   localparam logic [OP_W-1:0] OP_SRA  = 4'd5;
   localparam logic [OP_W-1:0] OP_SLL  = 4'd6;
   localparam logic [OP_W-1:0] OP_XOR  = 4'd7;
   localparam logic [OP_W-1:0] OP_SLT  = 4'd8;
   localparam logic [OP_W-1:0] OP_SLTU = 4'd9;
   localparam logic [OP_W-1:0] OP_MUL  = 4'd10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: result, signed overflow and illegal-op flag.
// MUL yields zero here; the sequential wrapper computes it iteratively.
module alu_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [OP_W-1:0]  op,
   output logic [WIDTH-1:0] result,
   output logic             ovf,
   output logic             illegal
);

   logic [WIDTH-1:0]        sum;
   logic [WIDTH-1:0]        diff;
   logic [SHW-1:0]          shamt;
   logic signed [WIDTH-1:0] a_s;
   logic signed [WIDTH-1:0] b_s;

   assign sum   = A + B;
   assign diff  = A - B;
   assign shamt = B[SHW-1:0];
   assign a_s   = A;
   assign b_s   = B;

   always_comb begin
      result  = '0;
      ovf     = 1'b0;
      illegal = 1'b0;
      case (op)
         OP_ADD: begin
            result = sum;
            ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            result = diff;
            ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
         OP_AND:  result = A & B;
         OP_OR:   result = A | B;
         OP_SRL:  result = A >> shamt;
         OP_SRA:  result = a_s >>> shamt;
         OP_SLL:  result = A << shamt;
         OP_XOR:  result = A ^ B;
         OP_SLT:  result[0] = a_s < b_s;
         OP_SLTU: result[0] = A < B;
         OP_MUL:  result = '0;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: registers results of single-cycle ops with latency 1 and
// runs MUL as a WIDTH-cycle shift-add, stalling the producer meanwhile.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [OP_W-1:0]  ALUOp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] C,
   output logic             zero,
   output logic             ovf,
   output logic             illegal,
   output logic [1:0]       dbg_state
);

   localparam int CW = SHW + 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

   state_e           state;
   state_e           state_next;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic [CW-1:0]    cnt;
   logic             accept;
   logic             is_mul;
   logic [WIDTH-1:0] comb_result;
   logic             comb_ovf;
   logic             comb_illegal;

   alu_comb #(.WIDTH(WIDTH), .SHW(SHW)) u_comb (
      .A       (A),
      .B       (B),
      .op      (ALUOp),
      .result  (comb_result),
      .ovf     (comb_ovf),
      .illegal (comb_illegal)
   );

   // Handshake: a bundle is taken on any edge where in_valid && in_ready;
   // a result is consumed on any edge where out_valid && out_ready.
   assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign is_mul    = (ALUOp == OP_MUL);
   assign out_valid = (state == S_DONE);
   assign dbg_state = state;
   assign acc_next  = acc + (mplier[0] ? mcand : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (accept)                          state_next = is_mul ? S_MUL : S_DONE;
            else if (state == S_DONE && out_ready) state_next = S_IDLE;
         end
         S_MUL: begin
            if (cnt == CW'(1)) state_next = S_DONE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         C       <= '0;
         zero    <= 1'b0;
         ovf     <= 1'b0;
         illegal <= 1'b0;
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         cnt     <= '0;
      end else begin
         if (accept && !is_mul) begin
            C       <= comb_result;
            zero    <= (comb_result == '0);
            ovf     <= comb_ovf;
            illegal <= comb_illegal;
         end else if (accept && is_mul) begin
            mcand  <= A;
            mplier <= B;
            acc    <= '0;
            cnt    <= CNT_INIT;
         end
         if (state == S_MUL) begin
            // One multiplier bit per edge; the last step lands straight in C.
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
               C       <= acc_next;
               zero    <= (acc_next == '0);
               ovf     <= 1'b0;
               illegal <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32, plus a WIDTH=8 instance for the
// narrow-shift and narrow-multiply cases.
module tb_alu_seq;
   import alu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  alu_op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] c;
   logic        zero;
   logic        ovf;
   logic        illegal;
   logic [1:0]  dbg_state;

   logic        in_valid8;
   logic        in_ready8;
   logic [7:0]  a8;
   logic [7:0]  b8;
   logic [3:0]  alu_op8;
   logic        out_valid8;
   logic        out_ready8;
   logic [7:0]  c8;
   logic        zero8;
   logic        ovf8;
   logic        illegal8;
   logic [1:0]  dbg_state8;

   int n_pass;
   int n_total;
   logic [31:0] exp_q[$];

   alu_seq #(.WIDTH(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(a), .B(b), .ALUOp(alu_op), .out_valid(out_valid), .out_ready(out_ready),
      .C(c), .zero(zero), .ovf(ovf), .illegal(illegal), .dbg_state(dbg_state)
   );

   alu_seq #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .A(a8), .B(b8), .ALUOp(alu_op8), .out_valid(out_valid8), .out_ready(out_ready8),
      .C(c8), .zero(zero8), .ovf(ovf8), .illegal(illegal8), .dbg_state(dbg_state8)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a bundle and wait (bounded) for the edge that accepts it.
   task automatic issue(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
      logic taken;
      taken    = 1'b0;
      alu_op   = op;
      a        = va;
      b        = vb;
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !taken; i++) begin
         taken = in_ready;
         step();
      end
      in_valid = 1'b0;
      chk("accept", {63'd0, taken}, 64'd1);
   endtask

   task automatic consume();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("consumed", {63'd0, out_valid}, 64'd0);
   endtask

   task automatic check_result(input string tag, input logic [31:0] ec, input logic ez,
                               input logic eo, input logic ei);
      chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
      chk({tag, "_c"}, {32'd0, c}, {32'd0, ec});
      chk({tag, "_zero"}, {63'd0, zero}, {63'd0, ez});
      chk({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
      chk({tag, "_illegal"}, {63'd0, illegal}, {63'd0, ei});
   endtask

   initial begin
      logic saw_ready;
      logic saw_valid;
      logic c_moved;
      int   cycles;

      n_pass     = 0;
      n_total    = 0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      a          = '0;
      b          = '0;
      alu_op     = '0;
      in_valid8  = 1'b0;
      out_ready8 = 1'b0;
      a8         = '0;
      b8         = '0;
      alu_op8    = '0;
      repeat (3) step();

      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_c", {32'd0, c}, 64'd0);
      chk("rst_flags", {61'd0, zero, ovf, illegal}, 64'd0);
      chk("rst_state", {62'd0, dbg_state}, {62'd0, S_IDLE});
      rst_n = 1'b1;
      step();
      chk("idle_in_ready", {63'd0, in_ready}, 64'd1);

      // Single-cycle ops, latency 1
      issue(OP_ADD, 32'h7FFF_FFFF, 32'h1);
      check_result("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      consume();
      issue(OP_SUB, 32'd5, 32'd5);
      check_result("sub_zero", 32'h0, 1'b1, 1'b0, 1'b0);
      consume();
      issue(OP_SUB, 32'h8000_0000, 32'h1);
      check_result("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
      consume();
      issue(OP_SRA, 32'h8000_0000, 32'h24);
      check_result("sra", 32'hF800_0000, 1'b0, 1'b0, 1'b0);
      consume();
      issue(OP_SRL, 32'h8000_0000, 32'h24);
      check_result("srl", 32'h0800_0000, 1'b0, 1'b0, 1'b0);
      consume();
      issue(OP_SLT, 32'hFFFF_FFFF, 32'h1);
      check_result("slt", 32'h1, 1'b0, 1'b0, 1'b0);
      consume();
      issue(OP_SLTU, 32'hFFFF_FFFF, 32'h1);
      check_result("sltu", 32'h0, 1'b1, 1'b0, 1'b0);
      consume();
      issue(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
      check_result("and", 32'h00F0_1200, 1'b0, 1'b0, 1'b0);
      consume();
      issue(OP_OR, 32'hF000_0001, 32'h0000_0F00);
      check_result("or", 32'hF000_0F01, 1'b0, 1'b0, 1'b0);
      consume();
      issue(4'd13, 32'd5, 32'd6);
      check_result("illegal", 32'h0, 1'b1, 1'b0, 1'b1);
      consume();

      // MUL: result exactly WIDTH edges after accept, producer stalled
      issue(OP_MUL, 32'h0001_0001, 32'h0001_0001);
      saw_ready = 1'b0;
      cycles    = 0;
      while (!out_valid && cycles < 100) begin
         if (in_ready) saw_ready = 1'b1;
         step();
         cycles++;
      end
      chk("mul_latency", 64'(cycles), 64'd32);
      chk("mul_in_ready_low", {63'd0, saw_ready}, 64'd0);
      check_result("mul", 32'h0002_0001, 1'b0, 1'b0, 1'b0);
      consume();

      // Backpressure: ADD result held, waiting XOR not taken
      issue(OP_ADD, 32'd3, 32'd4);
      alu_op    = OP_XOR;
      a         = 32'hFF;
      b         = 32'h0F;
      in_valid  = 1'b1;
      saw_ready = 1'b0;
      c_moved   = 1'b0;
      saw_valid = 1'b1;
      repeat (4) begin
         if (in_ready) saw_ready = 1'b1;
         if (c !== 32'd7) c_moved = 1'b1;
         if (!out_valid) saw_valid = 1'b0;
         step();
      end
      chk("bp_in_ready_low", {63'd0, saw_ready}, 64'd0);
      chk("bp_c_stable", {63'd0, c_moved}, 64'd0);
      chk("bp_valid_held", {63'd0, saw_valid}, 64'd1);
      chk("bp_c", {32'd0, c}, 64'd7);
      out_ready = 1'b1;
      #1;
      chk("bp_in_ready_comb", {63'd0, in_ready}, 64'd1);
      step();
      in_valid = 1'b0;
      check_result("bp_xor", 32'hF0, 1'b0, 1'b0, 1'b0);
      step();
      chk("bp_drain", {63'd0, out_valid}, 64'd0);

      // Streaming: 10 back-to-back ADDs, one result per cycle, in order
      for (int i = 0; i < 10; i++) begin
         alu_op   = OP_ADD;
         a        = 32'(i * 3 + 1);
         b        = 32'h1000_0000 + 32'(i);
         in_valid = 1'b1;
         exp_q.push_back(32'(i * 3 + 1) + 32'h1000_0000 + 32'(i));
         step();
         chk("stream_valid", {63'd0, out_valid}, 64'd1);
         chk("stream_c", {32'd0, c}, {32'd0, exp_q.pop_front()});
      end
      in_valid = 1'b0;
      step();
      chk("stream_drain", {63'd0, out_valid}, 64'd0);
      out_ready = 1'b0;

      // WIDTH=8 instance: shift amount uses low 3 bits, narrow MUL
      alu_op8   = OP_SLL;
      a8        = 8'h81;
      b8        = 8'h09;
      in_valid8 = 1'b1;
      step();
      in_valid8 = 1'b0;
      chk("w8_sll_valid", {63'd0, out_valid8}, 64'd1);
      chk("w8_sll_c", {56'd0, c8}, 64'h02);
      out_ready8 = 1'b1;
      step();
      out_ready8 = 1'b0;
      alu_op8   = OP_MUL;
      a8        = 8'd13;
      b8        = 8'd11;
      in_valid8 = 1'b1;
      step();
      in_valid8 = 1'b0;
      cycles    = 0;
      while (!out_valid8 && cycles < 50) begin
         step();
         cycles++;
      end
      chk("w8_mul_latency", 64'(cycles), 64'd8);
      chk("w8_mul_c", {56'd0, c8}, 64'h8F);
      out_ready8 = 1'b1;
      step();
      out_ready8 = 1'b0;

      // Reset in the middle of a MUL discards it
      out_ready = 1'b1;
      issue(OP_MUL, 32'd7, 32'd6);
      repeat (5) step();
      rst_n = 1'b0;
      #1;
      chk("rst_mid_state", {62'd0, dbg_state}, {62'd0, S_IDLE});
      step();
      rst_n = 1'b1;
      step();
      chk("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_mid_c", {32'd0, c}, 64'd0);
      chk("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
      saw_valid = 1'b0;
      repeat (40) begin
         if (out_valid) saw_valid = 1'b1;
         step();
      end
      chk("rst_mid_no_result", {63'd0, saw_valid}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
